wide_add_initiator: RTL and testbench

Requester-side sequencer for the 9-bit REQ/ACK adder. It accepts a wide addition of 9·NLIMB bits and splits it into 9-bit limbs. Each limb is issued to the adder as a four-phase REQ/ACK transaction, and carry is propagated between limbs with an extra "+1" transaction. It sits between datapath control and one 9-bit adder instance, whose REQ/ACK/Z/COUT pins it drives and samples.

---
 rtl/wide_add_initiator.sv | 221 ++++++++++++++++++++++
 tb/tb_wide_add_initiator.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_initiator.sv
// Sequencer that performs a 9*NLIMB-bit addition as a series of 9-bit REQ/ACK adder transactions.
// Optional handshake timeout is compiled in when ADD_TIMEOUT_EN is defined.
module wide_add_initiator #(
    parameter int NLIMB = 3
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic               START,
    input  logic [9*NLIMB-1:0] OPA,
    input  logic [9*NLIMB-1:0] OPB,
    output logic [9*NLIMB-1:0] SUM,
    output logic               CARRY,
    output logic               DONE,
    output logic               ERR,
    output logic               BUSY,
    output logic               ADD_REQ,
    output logic [8:0]         ADD_A,
    output logic [8:0]         ADD_B,
    input  logic [8:0]         ADD_Z,
    input  logic               ADD_COUT,
    input  logic               ADD_ACK,
    output logic [1:0]         fsm_state
);
    localparam int IW = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NLIMB - 1);

    typedef enum logic [1:0] {IDLE, ISSUE_AB, ISSUE_C1, GAP} state_t;

    state_t                state_q, state_n;
    logic [NLIMB-1:0][8:0] op_a_q, op_a_n;
    logic [NLIMB-1:0][8:0] op_b_q, op_b_n;
    logic [NLIMB-1:0][8:0] sum_q, sum_n;
    logic [IW-1:0]         idx_q, idx_n, idx_inc;
    logic                  carry_q, carry_n;
    logic                  t_q, t_n;
    logic                  c1_q, c1_n;
    logic                  gap_q, gap_n;
    logic                  carry_out_q, carry_out_n;
    logic                  done_q, done_n;
    logic                  busy_q, busy_n;
    logic                  req_q, req_n;
    logic [8:0]            add_a_q, add_a_n;
    logic [8:0]            add_b_q, add_b_n;
    logic                  last;
`ifdef ADD_TIMEOUT_EN
    logic [5:0]            tmo_q, tmo_n;
    logic                  err_q, err_n;
`endif

    assign last    = (idx_q == LAST);
    assign idx_inc = idx_q + IW'(1);

    always_comb begin
        state_n     = state_q;
        op_a_n      = op_a_q;
        op_b_n      = op_b_q;
        sum_n       = sum_q;
        idx_n       = idx_q;
        carry_n     = carry_q;
        t_n         = t_q;
        c1_n        = c1_q;
        gap_n       = gap_q;
        carry_out_n = carry_out_q;
        done_n      = 1'b0;
        busy_n      = busy_q;
        req_n       = req_q;
        add_a_n     = add_a_q;
        add_b_n     = add_b_q;
`ifdef ADD_TIMEOUT_EN
        err_n       = 1'b0;
        tmo_n       = (state_q == ISSUE_AB || state_q == ISSUE_C1) ? tmo_q + 6'd1 : 6'd0;
`endif
        case (state_q)
            IDLE: begin
                if (START) begin
                    op_a_n      = OPA;
                    op_b_n      = OPB;
                    sum_n       = '0;
                    carry_n     = 1'b0;
                    carry_out_n = 1'b0;
                    idx_n       = '0;
                    busy_n      = 1'b1;
                    req_n       = 1'b1;
                    add_a_n     = OPA[8:0];
                    add_b_n     = OPB[8:0];
                    state_n     = ISSUE_AB;
                end
            end
            ISSUE_AB: begin
                if (ADD_ACK) begin
                    sum_n[idx_q] = ADD_Z;
                    t_n          = ADD_COUT;
                    req_n        = 1'b0;
                    gap_n        = 1'b0;
                    state_n      = GAP;
                    // An incoming carry needs a follow-up +1 before the limb is final.
                    if (carry_q) begin
                        c1_n = 1'b1;
                    end else begin
                        c1_n    = 1'b0;
                        carry_n = ADD_COUT;
                        if (last) begin
                            done_n      = 1'b1;
                            carry_out_n = ADD_COUT;
                        end
                    end
                end
            end
            ISSUE_C1: begin
                if (ADD_ACK) begin
                    sum_n[idx_q] = ADD_Z;
                    carry_n      = t_q | ADD_COUT;
                    c1_n         = 1'b0;
                    req_n        = 1'b0;
                    gap_n        = 1'b0;
                    state_n      = GAP;
                    if (last) begin
                        done_n      = 1'b1;
                        carry_out_n = t_q | ADD_COUT;
                    end
                end
            end
            GAP: begin
                gap_n = 1'b1;
                if (gap_q) begin
                    gap_n = 1'b0;
                    if (c1_q) begin
                        state_n = ISSUE_C1;
                        req_n   = 1'b1;
                        add_a_n = sum_q[idx_q];
                        add_b_n = 9'd1;
                    end else if (!last) begin
                        idx_n   = idx_inc;
                        state_n = ISSUE_AB;
                        req_n   = 1'b1;
                        add_a_n = op_a_q[idx_inc];
                        add_b_n = op_b_q[idx_inc];
                    end else begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
`ifdef ADD_TIMEOUT_EN
        // Abandon the operation; forcing the last index makes GAP exit to IDLE.
        if ((state_q == ISSUE_AB || state_q == ISSUE_C1) && !ADD_ACK && tmo_q == 6'd63) begin
            req_n       = 1'b0;
            done_n      = 1'b1;
            err_n       = 1'b1;
            sum_n       = '0;
            carry_out_n = 1'b0;
            carry_n     = 1'b0;
            c1_n        = 1'b0;
            gap_n       = 1'b0;
            idx_n       = LAST;
            state_n     = GAP;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q     <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            t_q         <= 1'b0;
            c1_q        <= 1'b0;
            gap_q       <= 1'b0;
            carry_out_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            req_q       <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
`ifdef ADD_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_n;
            op_a_q      <= op_a_n;
            op_b_q      <= op_b_n;
            sum_q       <= sum_n;
            idx_q       <= idx_n;
            carry_q     <= carry_n;
            t_q         <= t_n;
            c1_q        <= c1_n;
            gap_q       <= gap_n;
            carry_out_q <= carry_out_n;
            done_q      <= done_n;
            busy_q      <= busy_n;
            req_q       <= req_n;
            add_a_q     <= add_a_n;
            add_b_q     <= add_b_n;
`ifdef ADD_TIMEOUT_EN
            tmo_q       <= tmo_n;
            err_q       <= err_n;
`endif
        end
    end

    assign SUM       = sum_q;
    assign CARRY     = carry_out_q;
    assign DONE      = done_q;
    assign BUSY      = busy_q;
    assign ADD_REQ   = req_q;
    assign ADD_A     = add_a_q;
    assign ADD_B     = add_b_q;
    assign fsm_state = state_q;
`ifdef ADD_TIMEOUT_EN
    assign ERR       = err_q;
`else
    assign ERR       = 1'b0;
`endif

endmodule

// File: tb/tb_wide_add_initiator.sv
// Bench for wide_add_initiator: behavioural 9-bit REQ/ACK adder, arithmetic reference model,
// scoreboard queues for results and adder transactions.
module tb_wide_add_initiator;
    localparam int NLIMB = 3;
    localparam int W     = 9 * NLIMB;

    logic         CLK = 1'b0;
    logic         RSTN;
    logic         START;
    logic [W-1:0] OPA, OPB, SUM;
    logic         CARRY, DONE, ERR, BUSY, ADD_REQ, ADD_COUT, ADD_ACK;
    logic [8:0]   ADD_A, ADD_B, ADD_Z;
    logic [1:0]   fsm_state;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;
    bit ack_en = 1'b1;
    int ast    = 0;

    logic [W+1:0] exp_q[$];   // {err, carry, sum}
    int           cyc_q[$];   // expected DONE cycle
    logic [17:0]  txn_q[$];   // expected {ADD_A, ADD_B} per transaction

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    wide_add_initiator #(.NLIMB(NLIMB)) dut (
        .CLK(CLK), .RSTN(RSTN), .START(START), .OPA(OPA), .OPB(OPB),
        .SUM(SUM), .CARRY(CARRY), .DONE(DONE), .ERR(ERR), .BUSY(BUSY),
        .ADD_REQ(ADD_REQ), .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_Z(ADD_Z),
        .ADD_COUT(ADD_COUT), .ADD_ACK(ADD_ACK), .fsm_state(fsm_state)
    );

    // Four-phase adder: ACK one cycle after REQ, wait for release, one end-state cycle.
    always @(posedge CLK) begin
        if (!RSTN) begin
            ADD_ACK  <= 1'b0;
            ADD_Z    <= '0;
            ADD_COUT <= 1'b0;
            ast      <= 0;
        end else begin
            case (ast)
                0: if (ADD_REQ && ack_en) begin
                    {ADD_COUT, ADD_Z} <= 10'(ADD_A) + 10'(ADD_B);
                    ADD_ACK <= 1'b1;
                    ast     <= 1;
                end
                1: begin
                    ADD_ACK <= 1'b0;
                    if (!ADD_REQ) ast <= 2;
                end
                default: ast <= 0;
            endcase
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: plain wide addition; a limb gets an extra +1 transaction when the
    // lower limbs produce a carry into it.
    task automatic push_op(input logic [W-1:0] a, input logic [W-1:0] b, input int t0);
        logic [W:0]   full;
        logic [W:0]   low;
        logic [W-1:0] mask;
        logic [8:0]   ai, bi, s9;
        int           ntx;
        full = {1'b0, a} + {1'b0, b};
        ntx  = 0;
        for (int i = 0; i < NLIMB; i++) begin
            ai   = 9'(a >> (9 * i));
            bi   = 9'(b >> (9 * i));
            mask = W'((64'd1 << (9 * i)) - 64'd1);
            low  = {1'b0, a & mask} + {1'b0, b & mask};
            s9   = ai + bi;
            txn_q.push_back({ai, bi});
            ntx++;
            if ((low >> (9 * i)) != 0) begin
                txn_q.push_back({s9, 9'd1});
                ntx++;
            end
        end
        exp_q.push_back({1'b0, full[W], full[W-1:0]});
        cyc_q.push_back(t0 + 4 * ntx - 1);
    endtask

    function automatic int count_tx(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0]   low;
        logic [W-1:0] mask;
        int           n;
        n = NLIMB;
        for (int i = 1; i < NLIMB; i++) begin
            mask = W'((64'd1 << (9 * i)) - 64'd1);
            low  = {1'b0, a & mask} + {1'b0, b & mask};
            if ((low >> (9 * i)) != 0) n++;
        end
        return n;
    endfunction

    // Drive one operation; returns in cycle 4T+1 so the next call starts back-to-back.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit mid);
        int t0, ntx;
        t0    = cyc;
        ntx   = count_tx(a, b);
        START = 1'b1;
        OPA   = a;
        OPB   = b;
        push_op(a, b, t0);
        @(negedge CLK);
        START = 1'b0;
        OPA   = W'($urandom);
        OPB   = W'($urandom);
        check("req_rise", ADD_REQ, 1);
        for (int k = 2; k <= 4 * ntx; k++) begin
            @(negedge CLK);
            if (mid && k == 5) begin
                START = 1'b1;
                OPA   = W'($urandom);
                OPB   = W'($urandom);
            end else begin
                START = 1'b0;
            end
        end
        check("busy_hold", BUSY, 1);
        @(negedge CLK);
        check("busy_drop", BUSY, 0);
    endtask

    function automatic logic [8:0] pick();
        case ($urandom_range(0, 2))
            0:       return 9'h000;
            1:       return 9'h1FF;
            default: return 9'h001;
        endcase
    endfunction

    task automatic gen(output logic [W-1:0] a, output logic [W-1:0] b);
        a = W'($urandom);
        b = W'($urandom);
        case ($urandom_range(0, 3))
            1: b = ~a;
            2: begin
                a = '1;
                b = W'($urandom_range(0, 3));
            end
            3: begin
                a = '0;
                b = '0;
                for (int i = 0; i < NLIMB; i++) begin
                    a = a | (W'(pick()) << (9 * i));
                    b = b | (W'(pick()) << (9 * i));
                end
            end
            default: ;
        endcase
    endtask

    // Result monitor
    initial begin : mon_done
        logic [W+1:0] e;
        int           ec;
        forever begin
            @(negedge CLK);
            if (RSTN && DONE) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: DONE=1 with no operation outstanding at cycle %0d", cyc);
                end else begin
                    e  = exp_q.pop_front();
                    ec = cyc_q.pop_front();
                    check("done_sum", SUM, e[W-1:0]);
                    check("done_carry", CARRY, e[W]);
                    check("done_err", ERR, e[W+1]);
                    check("done_cycle", cyc, ec);
                end
            end
        end
    end

    // Adder-side transaction monitor: operands checked every cycle REQ is high.
    initial begin : mon_txn
        logic        req_prev;
        logic [17:0] cur;
        req_prev = 1'b0;
        cur      = '0;
        forever begin
            @(negedge CLK);
            if (!RSTN) begin
                req_prev = 1'b0;
            end else begin
                if (ADD_REQ && !req_prev) begin
                    if (txn_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL txn_extra: ADD_REQ rose with A=0x%0h B=0x%0h, none expected", ADD_A, ADD_B);
                    end else begin
                        cur = txn_q.pop_front();
                    end
                end
                if (ADD_REQ) begin
                    check("add_a", ADD_A, cur[17:9]);
                    check("add_b", ADD_B, cur[8:0]);
                end
                req_prev = ADD_REQ;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1);
    end

    initial begin : main
        logic [W-1:0] a, b;
        int           n_hi;
        RSTN  = 1'b0;
        START = 1'b0;
        OPA   = '0;
        OPB   = '0;
        repeat (3) @(negedge CLK);
        check("rst_sum", SUM, 0);
        check("rst_carry", CARRY, 0);
        check("rst_done", DONE, 0);
        check("rst_err", ERR, 0);
        check("rst_busy", BUSY, 0);
        check("rst_req", ADD_REQ, 0);
        check("rst_add_a", ADD_A, 0);
        check("rst_add_b", ADD_B, 0);
        check("rst_state", fsm_state, 0);
        RSTN = 1'b1;
        @(negedge CLK);

        do_op(W'(5), W'(7), 1'b0);
        do_op(W'(27'h1FF), W'(1), 1'b0);
        do_op(W'(27'h7FFFFFF), W'(1), 1'b0);
        do_op(W'(27'h2AB_1FF), W'(27'h154_001), 1'b1);
        do_op(W'(5), W'(7), 1'b0);
        for (int n = 0; n < 20; n++) begin
            gen(a, b);
            do_op(a, b, 1'($urandom_range(0, 1)));
        end

        // Reset while the second transaction has REQ high
        START = 1'b1;
        OPA   = W'(27'h123);
        OPB   = W'(27'h045);
        push_op(OPA, OPB, cyc);
        @(negedge CLK);
        START = 1'b0;
        repeat (5) @(negedge CLK);
        check("rst_mid_req_pre", ADD_REQ, 1);
        RSTN = 1'b0;
        @(negedge CLK);
        check("rst_mid_req", ADD_REQ, 0);
        check("rst_mid_busy", BUSY, 0);
        check("rst_mid_sum", SUM, 0);
        check("rst_mid_done", DONE, 0);
        exp_q.delete();
        cyc_q.delete();
        txn_q.delete();
        RSTN = 1'b1;
        repeat (30) @(negedge CLK);
        check("rst_mid_quiet", BUSY, 0);

        // Adder never acknowledges
        ack_en = 1'b0;
        a      = W'($urandom);
        b      = W'($urandom);
        START  = 1'b1;
        OPA    = a;
        OPB    = b;
        txn_q.push_back({a[8:0], b[8:0]});
`ifdef ADD_TIMEOUT_EN
        exp_q.push_back({1'b1, 1'b0, {W{1'b0}}});
        cyc_q.push_back(cyc + 65);
        @(negedge CLK);
        START = 1'b0;
        repeat (65) @(negedge CLK);
        check("tmo_busy_hold", BUSY, 1);
        @(negedge CLK);
        check("tmo_busy_drop", BUSY, 0);
`else
        @(negedge CLK);
        START = 1'b0;
        n_hi  = 0;
        repeat (200) begin
            @(negedge CLK);
            if (ADD_REQ) n_hi++;
        end
        check("stall_req_cycles", n_hi, 200);
        check("stall_busy", BUSY, 1);
        RSTN = 1'b0;
        @(negedge CLK);
        txn_q.delete();
        RSTN = 1'b1;
        @(negedge CLK);
`endif
        ack_en = 1'b1;
        repeat (4) @(negedge CLK);
        gen(a, b);
        do_op(a, b, 1'b0);

        repeat (4) @(negedge CLK);
        check("pending_done", exp_q.size(), 0);
        check("pending_txn", txn_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
